// File: rtl/spi_txn_ctrl.sv
// spi_txn_ctrl: SPI command/burst sequencer driving the register mux (address, write strobes, read loads).
module spi_txn_ctrl #(
  parameter logic [6:0]  MAX_ADDR   = 7'h09,
  parameter logic [15:0] NOINC_MASK = 16'h0128
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cs_n,
  input  logic       byte_dv,
  input  logic [7:0] byte_in,
  input  logic [7:0] tx_d,
  input  logic       tx_en,
  output logic [6:0] reg_addr,
  output logic       addr_dv,
  output logic       rw_out,
  output logic       rxdv,
  output logic [7:0] rx_d,
  output logic       tx_load,
  output logic [7:0] tx_byte,
  output logic       rd_strobe,
  output logic       busy,
  output logic [7:0] err_cnt
);
  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] CMD     = 3'd1;
  localparam logic [2:0] WR_DATA = 3'd2;
  localparam logic [2:0] RD_DATA = 3'd3;
  localparam logic [2:0] DRAIN   = 3'd4;
  logic [2:0] state;
  logic       load_pend, rd_ovf, hold, ovf, err_inc;
  logic [6:0] nxt;
  always_comb begin
    hold    = (reg_addr < 7'd16) && NOINC_MASK[reg_addr[3:0]];
    nxt     = hold ? reg_addr : reg_addr + 7'd1;
    ovf     = !hold && (nxt > MAX_ADDR || nxt == 7'd0);
    err_inc = !cs_n && ((state == CMD && byte_dv && byte_in[6:0] > MAX_ADDR) ||
                        (state == WR_DATA && rxdv && ovf) ||
                        (state == RD_DATA && rd_strobe && rd_ovf));
  end
  assign addr_dv = state == WR_DATA || state == RD_DATA;
  assign busy    = state != IDLE;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      reg_addr  <= '0;
      rw_out    <= 1'b0;
      rxdv      <= 1'b0;
      rx_d      <= '0;
      tx_load   <= 1'b0;
      tx_byte   <= '0;
      rd_strobe <= 1'b0;
      err_cnt   <= '0;
      load_pend <= 1'b0;
      rd_ovf    <= 1'b0;
    end else begin
      rxdv      <= 1'b0;
      tx_load   <= 1'b0;
      rd_strobe <= 1'b0;
      if (err_inc && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
      if (cs_n) begin
        state     <= IDLE;
        rw_out    <= 1'b0;
        load_pend <= 1'b0;
        rd_ovf    <= 1'b0;
      end else begin
        case (state)
          IDLE: state <= CMD;
          CMD: if (byte_dv) begin
            rw_out    <= byte_in[7];
            reg_addr  <= byte_in[6:0];
            load_pend <= byte_in[7] && byte_in[6:0] <= MAX_ADDR;
            state     <= byte_in[6:0] > MAX_ADDR ? DRAIN : byte_in[7] ? RD_DATA : WR_DATA;
          end
          WR_DATA: begin
            if (rxdv) begin
              if (ovf) state <= DRAIN;
              else reg_addr <= nxt;
            end
            if (byte_dv) begin
              rxdv <= 1'b1;
              rx_d <= byte_in;
            end
          end
          RD_DATA: begin
            if (load_pend) begin
              tx_load   <= 1'b1;
              tx_byte   <= tx_en ? tx_d : 8'h00;
              load_pend <= 1'b0;
            end
            if (rd_strobe && rd_ovf) state <= DRAIN;
            // address moves with the strobe so the reload samples the new source
            if (byte_dv) begin
              rd_strobe <= 1'b1;
              rd_ovf    <= ovf;
              load_pend <= !ovf;
              if (!ovf) reg_addr <= nxt;
            end
          end
          DRAIN: state <= DRAIN;
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_spi_txn_ctrl.sv
// tb_spi_txn_ctrl: transaction-level checks of spi_txn_ctrl against a burst/address model.
module tb_spi_txn_ctrl;
  logic       clk = 0, reset_n = 0, cs_n = 1, byte_dv = 0, tx_en;
  logic [7:0] byte_in = 0, tx_d;
  logic [6:0] reg_addr;
  logic       addr_dv, rw_out, rxdv, tx_load, rd_strobe, busy;
  logic [7:0] rx_d, tx_byte, err_cnt;

  spi_txn_ctrl dut (
    .clk(clk), .reset_n(reset_n), .cs_n(cs_n), .byte_dv(byte_dv), .byte_in(byte_in),
    .tx_d(tx_d), .tx_en(tx_en), .reg_addr(reg_addr), .addr_dv(addr_dv), .rw_out(rw_out),
    .rxdv(rxdv), .rx_d(rx_d), .tx_load(tx_load), .tx_byte(tx_byte), .rd_strobe(rd_strobe),
    .busy(busy), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  // register file with address 7 unsourced, address 8 a show-ahead FIFO
  logic [7:0] mem [16];
  logic [7:0] fifo_mem [64];
  logic [5:0] fidx = 0;
  assign tx_d  = reg_addr == 7'd8 ? fifo_mem[fidx] : mem[reg_addr[3:0]];
  assign tx_en = reg_addr != 7'd7;

  int checks = 0, failures = 0;
  int wr_n = 0, ld_n = 0, rs_n = 0, adv_n = 0, bad = 0;
  logic [59:0] wr_sig = 0;
  logic [63:0] ld_sig = 0;
  logic [6:0]  last_addr = 0;

  always @(negedge clk) begin
    if (rxdv) begin wr_n++; wr_sig = {wr_sig[44:0], reg_addr, rx_d}; end
    if (tx_load) begin ld_n++; ld_sig = {ld_sig[55:0], tx_byte}; end
    if (rd_strobe) begin rs_n++; if (last_addr == 7'd8) fidx = fidx + 6'd1; end
    if (addr_dv) adv_n++;
    if ((rxdv && (!addr_dv || rw_out)) || (rd_strobe && (!addr_dv || !rw_out)) ||
        (addr_dv && reg_addr > 7'd9) || (tx_load && !addr_dv)) bad++;
    last_addr = reg_addr;
  end

  int          e_wr_n, e_ld_n, e_rs_n, e_err = 0, nb;
  logic [59:0] e_wr_sig;
  logic [63:0] e_ld_sig;
  logic [6:0]  e_addr;
  logic [7:0]  d [8];

  function automatic logic [7:0] val(input logic [6:0] a, input logic [5:0] mi);
    return a == 7'd8 ? fifo_mem[mi] : a == 7'd7 ? 8'h00 : mem[a[3:0]];
  endfunction

  task automatic model(input logic [7:0] cmd);
    logic [6:0] a, n;
    logic [5:0] mi;
    e_wr_n = wr_n; e_wr_sig = wr_sig; e_ld_n = ld_n; e_ld_sig = ld_sig; e_rs_n = rs_n;
    a = cmd[6:0]; mi = fidx; e_addr = a;
    if (a > 7'd9) begin
      e_err = e_err < 255 ? e_err + 1 : 255;
      return;
    end
    if (cmd[7]) begin e_ld_n++; e_ld_sig = {e_ld_sig[55:0], val(a, mi)}; end
    for (int i = 0; i < nb; i++) begin
      if (cmd[7]) begin e_rs_n++; if (a == 7'd8) mi = mi + 6'd1; end
      else begin e_wr_n++; e_wr_sig = {e_wr_sig[44:0], a, d[i]}; end
      n = (a == 7'd3 || a == 7'd5 || a == 7'd8) ? a : a + 7'd1;
      if (n > 7'd9 || n == 7'd0) begin e_err = e_err < 255 ? e_err + 1 : 255; break; end
      a = n;
      if (cmd[7]) begin e_ld_n++; e_ld_sig = {e_ld_sig[55:0], val(a, mi)}; end
    end
    e_addr = a;
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk); byte_dv = 1; byte_in = b;
    @(negedge clk); byte_dv = 0;
    repeat (4) @(negedge clk);
  endtask

  task automatic txn(input logic [7:0] cmd);
    model(cmd);
    @(negedge clk); cs_n = 0;
    repeat (2) @(negedge clk);
    send(cmd);
    for (int i = 0; i < nb; i++) send(d[i]);
    repeat (4) @(negedge clk);
    cs_n = 1;
    repeat (3) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk); reset_n = 0; cs_n = 1; byte_dv = 0;
    repeat (3) @(negedge clk);
    reset_n = 1; e_err = 0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({reg_addr, addr_dv, rw_out, rxdv, rx_d, tx_load, tx_byte, rd_strobe, busy, err_cnt} !== 37'd0) begin
      failures++;
      $display("FAIL reset_outputs: got addr=%h adv=%b rw=%b rxdv=%b rxd=%h ld=%b txb=%h rs=%b busy=%b err=%h want all 0",
               reg_addr, addr_dv, rw_out, rxdv, rx_d, tx_load, tx_byte, rd_strobe, busy, err_cnt);
    end
  endtask

  task automatic test_write_basic();
    int b0 = bad;
    nb = 1; d[0] = 8'h5A;
    txn(8'h00);
    checks++;
    if (wr_n !== e_wr_n || wr_sig[14:0] !== {7'd0, 8'h5A}) begin
      failures++; $display("FAIL write_basic: got n=%0d last=%h want n=%0d last=%h", wr_n, wr_sig[14:0], e_wr_n, {7'd0, 8'h5A});
    end
    checks++;
    if (busy !== 1'b0 || addr_dv !== 1'b0) begin
      failures++; $display("FAIL write_basic_idle: got busy=%b adv=%b want 0 0", busy, addr_dv);
    end
    checks++;
    if (bad !== b0) begin failures++; $display("FAIL write_basic_qual: got %0d bad strobes want 0", bad - b0); end
  endtask

  task automatic test_write_burst();
    nb = 4; d[0] = 8'h11; d[1] = 8'h22; d[2] = 8'h33; d[3] = 8'h44;
    txn(8'h06);
    checks++;
    if (wr_n !== e_wr_n || wr_sig !== e_wr_sig) begin
      failures++; $display("FAIL write_burst: got n=%0d sig=%h want n=%0d sig=%h", wr_n, wr_sig, e_wr_n, e_wr_sig);
    end
    checks++;
    if (reg_addr !== 7'd8) begin failures++; $display("FAIL write_burst_hold: got addr=%h want 08", reg_addr); end
  endtask

  task automatic test_fifo_read();
    int r0 = rs_n;
    fifo_mem[fidx] = 8'hA1; fifo_mem[fidx + 6'd1] = 8'hA2; fifo_mem[fidx + 6'd2] = 8'hA3;
    nb = 3; d[0] = 8'hFF; d[1] = 8'hFF; d[2] = 8'hFF;
    txn(8'h88);
    checks++;
    if (ld_n !== e_ld_n || ld_sig !== e_ld_sig || ld_sig[31:8] !== 24'hA1A2A3) begin
      failures++; $display("FAIL fifo_read_loads: got n=%0d sig=%h want n=%0d sig=%h", ld_n, ld_sig, e_ld_n, e_ld_sig);
    end
    checks++;
    if (rs_n - r0 !== 3 || reg_addr !== 7'd8) begin
      failures++; $display("FAIL fifo_read_strobes: got rs=%0d addr=%h want rs=3 addr=08", rs_n - r0, reg_addr);
    end
  endtask

  task automatic test_bad_cmd();
    int a0 = adv_n, w0 = wr_n;
    nb = 2; d[0] = 8'h12; d[1] = 8'h34;
    txn(8'h0C);
    checks++;
    if (adv_n !== a0 || wr_n !== w0) begin
      failures++; $display("FAIL bad_cmd_quiet: got adv_cycles=%0d writes=%0d want 0 0", adv_n - a0, wr_n - w0);
    end
    checks++;
    if (err_cnt !== 8'd1 || busy !== 1'b0) begin
      failures++; $display("FAIL bad_cmd_err: got err=%0d busy=%b want err=1 busy=0", err_cnt, busy);
    end
  endtask

  task automatic test_write_overflow();
    nb = 2; d[0] = 8'hC3; d[1] = 8'h3C;
    txn(8'h09);
    checks++;
    if (wr_n !== e_wr_n || wr_sig !== e_wr_sig || wr_sig[14:0] !== {7'd9, 8'hC3}) begin
      failures++; $display("FAIL write_overflow: got n=%0d sig=%h want n=%0d sig=%h", wr_n, wr_sig, e_wr_n, e_wr_sig);
    end
    checks++;
    if (err_cnt !== 8'd2 || reg_addr !== 7'd9) begin
      failures++; $display("FAIL write_overflow_err: got err=%0d addr=%h want err=2 addr=09", err_cnt, reg_addr);
    end
  endtask

  task automatic test_abort();
    int w0;
    @(negedge clk); cs_n = 0;
    repeat (2) @(negedge clk);
    send(8'h01);
    w0 = wr_n;
    @(negedge clk); byte_dv = 1; byte_in = 8'h77; cs_n = 1;
    @(negedge clk); byte_dv = 0;
    repeat (4) @(negedge clk);
    checks++;
    if (wr_n !== w0 || busy !== 1'b0 || rw_out !== 1'b0) begin
      failures++; $display("FAIL abort_cs_rise: got writes=%0d busy=%b rw=%b want 0 0 0", wr_n - w0, busy, rw_out);
    end
    nb = 1; d[0] = 8'h9E;
    txn(8'h02);
    checks++;
    if (wr_n !== e_wr_n || wr_sig !== e_wr_sig) begin
      failures++; $display("FAIL abort_recover: got n=%0d sig=%h want n=%0d sig=%h", wr_n, wr_sig, e_wr_n, e_wr_sig);
    end
  endtask

  task automatic test_reset_mid_read();
    int r0, l0;
    @(negedge clk); cs_n = 0;
    repeat (2) @(negedge clk);
    send(8'h81);
    r0 = rs_n; l0 = ld_n;
    @(negedge clk); reset_n = 0; byte_dv = 1; byte_in = 8'h00;
    @(negedge clk);
    checks++;
    if ({reg_addr, addr_dv, rw_out, rxdv, rx_d, tx_load, tx_byte, rd_strobe, busy, err_cnt} !== 37'd0) begin
      failures++;
      $display("FAIL reset_mid_read: got addr=%h adv=%b rw=%b rxdv=%b ld=%b txb=%h rs=%b busy=%b err=%h want all 0",
               reg_addr, addr_dv, rw_out, rxdv, tx_load, tx_byte, rd_strobe, busy, err_cnt);
    end
    reset_n = 1; byte_dv = 0; cs_n = 1; e_err = 0;
    repeat (6) @(negedge clk);
    checks++;
    if (rs_n !== r0 || ld_n !== l0) begin
      failures++; $display("FAIL reset_no_strobe: got rs=%0d loads=%0d after reset want 0 0", rs_n - r0, ld_n - l0);
    end
    nb = 2; d[0] = 8'h00; d[1] = 8'h00;
    txn(8'h84);
    checks++;
    if (ld_n !== e_ld_n || ld_sig !== e_ld_sig || rs_n !== e_rs_n || reg_addr !== e_addr) begin
      failures++; $display("FAIL reset_recover: got n=%0d sig=%h rs=%0d addr=%h want n=%0d sig=%h rs=%0d addr=%h",
                           ld_n, ld_sig, rs_n, reg_addr, e_ld_n, e_ld_sig, e_rs_n, e_addr);
    end
  endtask

  task automatic test_random();
    logic [7:0] cmd;
    int b0;
    for (int it = 0; it < 30; it++) begin
      for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
      for (int i = 0; i < 64; i++) fifo_mem[i] = 8'($urandom);
      cmd = {1'($urandom), 7'($urandom_range(0, 11))};
      nb = $urandom_range(0, 4);
      for (int i = 0; i < 8; i++) d[i] = 8'($urandom);
      b0 = bad;
      txn(cmd);
      checks++;
      if (wr_n !== e_wr_n || wr_sig !== e_wr_sig) begin
        failures++; $display("FAIL rand_writes cmd=%h: got n=%0d sig=%h want n=%0d sig=%h", cmd, wr_n, wr_sig, e_wr_n, e_wr_sig);
      end
      checks++;
      if (ld_n !== e_ld_n || ld_sig !== e_ld_sig || rs_n !== e_rs_n) begin
        failures++; $display("FAIL rand_reads cmd=%h: got n=%0d sig=%h rs=%0d want n=%0d sig=%h rs=%0d",
                             cmd, ld_n, ld_sig, rs_n, e_ld_n, e_ld_sig, e_rs_n);
      end
      checks++;
      if (err_cnt !== 8'(e_err) || reg_addr !== e_addr || busy !== 1'b0 || bad !== b0) begin
        failures++; $display("FAIL rand_state cmd=%h: got err=%0d addr=%h busy=%b bad=%0d want err=%0d addr=%h busy=0 bad=0",
                             cmd, err_cnt, reg_addr, busy, bad - b0, e_err, e_addr);
      end
    end
  endtask

  task automatic test_err_sat();
    nb = 0;
    for (int i = 0; i < 258; i++) txn(8'h8A);
    checks++;
    if (err_cnt !== 8'hFF) begin failures++; $display("FAIL err_saturate: got err=%0d want 255", err_cnt); end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 64; i++) fifo_mem[i] = 8'($urandom);
    test_reset();
    test_write_basic();
    test_write_burst();
    test_fifo_read();
    test_bad_cmd();
    test_write_overflow();
    test_abort();
    test_reset_mid_read();
    test_random();
    test_err_sat();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
